// File: rtl/or7_share_arbiter.sv
// rtl/or7_share_arbiter.sv - round-robin arbiter sharing one external or7/nor3 reduction unit
//
// Grants one of NREQ requesters at a time, drives its latched WIDTH-bit vector
// onto the shared reduction unit, and returns the unit's OR / NOR3 results
// together with a one-cycle ACK to the owning requester.
//
// Sequencing (one operation per pass, back-to-back with no idle gap):
//   IDLE -> DRIVE -> RESP -> IDLE                 3 cycles, REQ->ACK = 2 cycles
//   IDLE -> DRIVE -> WAIT -> RESP -> IDLE         OR7_ARB_PIPE_EN defined:
//                                                 4 cycles, REQ->ACK = 3 cycles
// Build option:
//   OR7_ARB_PIPE_EN  add a WAIT state and a register stage on U_OR/U_NOR
//                    for a registered or long-path shared unit.
//
// Parameters:
//   NREQ   number of requesters (2..8)
//   WIDTH  vector width driven to the shared unit (>=3, NOR taps bits [2:0])
//   IDW    requester index width, clog2(NREQ)
//
// Ports:
//   clk      in   1           clock, all state on rising edge
//   rst_n    in   1           asynchronous active-low reset
//   req      in   NREQ        req[i] high: requester i has a vector pending
//   din      in   NREQ*WIDTH  requester i vector at din[i*WIDTH +: WIDTH]
//   gnt      out  NREQ        one-hot grant, high while requester owns the unit
//   ack      out  NREQ        one-cycle pulse: result valid, din consumed
//   u_in     out  WIDTH       registered vector driven to the shared unit
//   u_or     in   1           shared unit OR of u_in
//   u_nor    in   1           shared unit NOR of u_in[2:0]
//   res_or   out  1           returned OR result, valid with res_vld
//   res_nor  out  1           returned NOR result, valid with res_vld
//   res_id   out  IDW         requester index the result belongs to
//   res_vld  out  1           one-cycle result strobe, coincident with ack

module or7_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 7,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      u_in,
  input  logic                  u_or,
  input  logic                  u_nor,
  output logic                  res_or,
  output logic                  res_nor,
  output logic [IDW-1:0]        res_id,
  output logic                  res_vld
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Index of the most recently served requester; it gets lowest priority next.
  logic [IDW-1:0]   ptr;

  logic [WIDTH-1:0] din_a [NREQ];
  logic             win_found;
  logic [IDW-1:0]   win_idx;

`ifdef OR7_ARB_PIPE_EN
  logic u_or_q;
  logic u_nor_q;
`endif

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      din_a[i] = din[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search starting just after ptr. Walking the offsets from the
  // far end down to 1 lets the nearest requester overwrite farther ones.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IDW'((int'(ptr) + k) % NREQ)]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found) state_nxt = S_DRIVE;
`ifdef OR7_ARB_PIPE_EN
      S_DRIVE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_RESP;
`else
      S_DRIVE: state_nxt = S_RESP;
      S_WAIT:  state_nxt = S_IDLE;
`endif
      S_RESP:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath. ack/res_vld are loaded on the edge that enters RESP, so they
  // are high for exactly the RESP cycle; ack reuses gnt since it already
  // holds the winner's one-hot code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      ack     <= '0;
      u_in    <= '0;
      res_or  <= 1'b0;
      res_nor <= 1'b0;
      res_id  <= '0;
      res_vld <= 1'b0;
      ptr     <= IDW'(NREQ - 1);
`ifdef OR7_ARB_PIPE_EN
      u_or_q  <= 1'b0;
      u_nor_q <= 1'b0;
`endif
    end else begin
      ack     <= '0;
      res_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            // Latch the vector so later din changes cannot disturb the op.
            u_in   <= din_a[win_idx];
            gnt    <= NREQ'(1) << win_idx;
            res_id <= win_idx;
          end else begin
            u_in   <= '0;
          end
        end
        S_DRIVE: begin
`ifdef OR7_ARB_PIPE_EN
          u_or_q  <= u_or;
          u_nor_q <= u_nor;
`else
          res_or  <= u_or;
          res_nor <= u_nor;
          ack     <= gnt;
          res_vld <= 1'b1;
`endif
        end
        S_WAIT: begin
`ifdef OR7_ARB_PIPE_EN
          res_or  <= u_or_q;
          res_nor <= u_nor_q;
          ack     <= gnt;
          res_vld <= 1'b1;
`endif
        end
        S_RESP: begin
          ptr  <= res_id;
          u_in <= '0;
          gnt  <= '0;
        end
      endcase
    end
  end

endmodule
